uart_pixel_packer: RTL

Sits between the UART receiver and the SDRAM write-FIFO port. It assembles received bytes into pixels in one of three selectable formats and expands each pixel to RGB888 by bit replication. It tracks the frame position in x/y, signals end of frame, and uses an inter-byte timeout to resynchronise after a broken transfer. It replaces the fixed one-byte, zero-filled pixel path with a parametrised, multi-format one.

---
 rtl/uart_pixel_packer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_pixel_packer.sv
// Assembles UART bytes into RGB332/RGB565/RGB888 pixels, expands them to RGB888,
// tracks frame x/y and aborts a stalled frame after an inter-byte timeout.
module uart_pixel_packer #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int TIMEOUT_CYC = 50000,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic [1:0]    mode,
  input  logic [7:0]    in_data,
  input  logic          in_flag,
  input  logic          wfifo_full,
  input  logic          clr_err,
  output logic [23:0]   pix_data,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_done,
  output logic          sync_err,
  output logic          ovf_err
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   sh_q, sh_d;
  logic [23:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          done_q, done_d;
  logic          sync_q, sync_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    eff_mode;
  logic [1:0]    last_idx;
  logic          complete;

  function automatic logic [23:0] expand(input logic [1:0] m, input logic [15:0] sh,
                                         input logic [7:0] b);
    logic [15:0] w;
    w = {sh[7:0], b};
    case (m)
      2'd1:    expand = {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
      2'd2:    expand = {sh, b};
      default: expand = {b[7:5], b[7:5], b[7:6], b[4:2], b[4:2], b[4:3], {4{b[1:0]}}};
    endcase
  endfunction

  // The first byte of a frame uses the live mode; later bytes use the latched one.
  always_comb begin
    eff_mode = (state_q == IDLE) ? ((mode == 2'd3) ? 2'd0 : mode) : mode_q;
    case (eff_mode)
      2'd1:    last_idx = 2'd1;
      2'd2:    last_idx = 2'd2;
      default: last_idx = 2'd0;
    endcase
    complete = in_flag && (idx_q == last_idx);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    sync_d  = sync_q;
    ovf_d   = ovf_q;

    if (clr_err) begin
      sync_d = 1'b0;
      ovf_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (in_flag) begin
          state_d = RECV;
          mode_d  = eff_mode;
        end
      end
      RECV: begin
        if (in_flag) begin
          tcnt_d = '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          tcnt_d  = '0;
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
          sync_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_flag) begin
      sh_d  = {sh_q[7:0], in_data};
      idx_d = complete ? 2'd0 : idx_q + 2'd1;
    end

    // Geometry advances even for a dropped pixel so the frame stays aligned.
    if (complete) begin
      if (wfifo_full) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = expand(eff_mode, sh_q, in_data);
      end
      if (x_q == XW'(IMG_W - 1)) begin
        x_d = '0;
        if (y_q == YW'(IMG_H - 1)) begin
          y_d     = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      sync_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pix_data   = data_q;
  assign pix_valid  = valid_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign frame_done = done_q;
  assign sync_err   = sync_q;
  assign ovf_err    = ovf_q;

endmodule
